// File: rtl/cu_strobe_encoder.sv
// cu_strobe_encoder: return-path encoder for the cu control-unit decoder.
// Buffers 11-bit strobe vectors (bit0 = p ... bit10 = z) in a small FIFO and
// serialises each one into 4-bit strobe-index codes, lowest set bit first.
// Optional feature macro: CU_ENC_PARITY_EN adds out_par_pad (even parity of the code).
module cu_strobe_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 11,
  parameter int unsigned CW    = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  input  logic             in_vld_pad,
  output logic             in_rdy_pad,
  input  logic [W-1:0]     strb_pad,
  output logic             out_vld_pad,
  input  logic             out_rdy_pad,
  output logic [CW-1:0]    out_code_pad,
  output logic             out_last_pad,
`ifdef CU_ENC_PARITY_EN
  output logic             out_par_pad,
`endif
  output logic [CNT_W-1:0] ev_cnt_pad
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  // FIFO storage and bookkeeping
  logic [W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              in_rdy_q, in_rdy_d;
  logic              push;
  logic              pop;

  // Serialiser state and registered outputs
  state_e            state_q, state_d;
  logic [W-1:0]      work_q, work_d;
  logic              out_vld_q, out_vld_d;
  logic [CW-1:0]     out_code_q, out_code_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  ev_cnt_q, ev_cnt_d;
  logic [W-1:0]      rem;

  // Index of the lowest set bit (0 when the vector is empty)
  function automatic logic [CW-1:0] lowest_idx(input logic [W-1:0] v);
    lowest_idx = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CW'(i);
    end
  endfunction

  // True when exactly one bit of the vector is set
  function automatic logic is_onehot(input logic [W-1:0] v);
    is_onehot = (v != '0) && ((v & (v - W'(1))) == '0);
  endfunction

  // All-zero vectors are accepted but never stored
  assign push = in_vld_pad & in_rdy_q & (|strb_pad);

  // FIFO pointer/count next-state; ready follows the registered count only
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
    in_rdy_d = (count_d != FCNT_W'(DEPTH));
  end

  // FIFO data array; contents are don't-care until written
  always_ff @(posedge clk_pad) begin
    if (push) mem_q[wr_ptr_q] <= strb_pad;
  end

  // FIFO control registers
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  // Serialiser next-state: IDLE pops a vector, EMIT presents one code per handshake
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    out_vld_d  = out_vld_q;
    out_code_d = out_code_q;
    out_last_d = out_last_q;
    ev_cnt_d   = ev_cnt_q;
    pop        = 1'b0;
    rem        = '0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          work_d  = mem_q[rd_ptr_q];
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!out_vld_q) begin
          // first cycle after the pop: register the first code of the vector
          out_vld_d  = 1'b1;
          out_code_d = lowest_idx(work_q);
          out_last_d = is_onehot(work_q);
        end else if (out_rdy_pad) begin
          rem      = work_q & ~(W'(1) << out_code_q);
          work_d   = rem;
          ev_cnt_d = ev_cnt_q + CNT_W'(1);
          if (out_last_q) begin
            state_d    = S_IDLE;
            out_vld_d  = 1'b0;
            out_code_d = '0;
            out_last_d = 1'b0;
          end else begin
            out_code_d = lowest_idx(rem);
            out_last_d = is_onehot(rem);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serialiser state and output registers
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      out_vld_q  <= 1'b0;
      out_code_q <= '0;
      out_last_q <= 1'b0;
      ev_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      out_vld_q  <= out_vld_d;
      out_code_q <= out_code_d;
      out_last_q <= out_last_d;
      ev_cnt_q   <= ev_cnt_d;
    end
  end

`ifdef CU_ENC_PARITY_EN
  logic out_par_q;

  // Parity tracks the code register, so it holds whenever the code holds
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) out_par_q <= 1'b0;
    else            out_par_q <= ^out_code_d;
  end

  assign out_par_pad = out_par_q;
`endif

  assign in_rdy_pad   = in_rdy_q;
  assign out_vld_pad  = out_vld_q;
  assign out_code_pad = out_code_q;
  assign out_last_pad = out_last_q;
  assign ev_cnt_pad   = ev_cnt_q;

endmodule

// File: tb/tb_cu_strobe_encoder.sv
// Testbench for cu_strobe_encoder: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_cu_strobe_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [10:0] strb;
  logic        out_vld;
  logic        out_rdy;
  logic [3:0]  out_code;
  logic        out_last;
  logic [15:0] ev_cnt;
`ifdef CU_ENC_PARITY_EN
  logic        out_par;
`endif

  int checks = 0;
  int errors = 0;

  cu_strobe_encoder dut (
    .clk_pad      (clk),
    .rst_n_pad    (rst_n),
    .in_vld_pad   (in_vld),
    .in_rdy_pad   (in_rdy),
    .strb_pad     (strb),
    .out_vld_pad  (out_vld),
    .out_rdy_pad  (out_rdy),
    .out_code_pad (out_code),
    .out_last_pad (out_last),
`ifdef CU_ENC_PARITY_EN
    .out_par_pad  (out_par),
`endif
    .ev_cnt_pad   (ev_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] strb;
    int          n;      // number of codes expected
    int          first;  // first code
    int          lastc;  // final code
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    strb    = '0;
    out_rdy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_vld(input string name);
    for (int t = 0; t < 10 && !out_vld; t++) step();
    chk(name, out_vld, 1'b1);
  endtask

  // reference model state
  int          mfifo[$];
  int          mcur[$];
  int          mst;   // 0 idle, 1 vector loaded, 2 code presented
  logic [15:0] mev;

  int          got;
  int          lastc;
  int          acc;
  logic [15:0] ev0;
  logic        seen;

  initial begin
    tbl[0] = '{11'h001, 1, 0, 0};
    tbl[1] = '{11'h402, 2, 1, 10};
    tbl[2] = '{11'h7FF, 11, 0, 10};
    tbl[3] = '{11'h400, 1, 10, 10};
    tbl[4] = '{11'h080, 1, 7, 7};
    tbl[5] = '{11'h555, 6, 0, 10};
    tbl[6] = '{11'h000, 0, 0, 0};
    tbl[7] = '{11'h300, 2, 8, 9};

    // reset values, sampled while reset is held
    rst_n = 1'b0; in_vld = 1'b0; strb = '0; out_rdy = 1'b0;
    #12;
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_code", out_code, 4'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_ev", ev_cnt, 16'd0);
    chk("rst_rdy", in_rdy, 1'b1);
    do_reset();

    // directed table with downstream always ready
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ev0 = ev_cnt;
      strb = tbl[i].strb; in_vld = 1'b1;
      step();                               // accepted at edge k
      in_vld = 1'b0; strb = '0;
      step();
      chk($sformatf("lat_pre[%0d]", i), out_vld, 1'b0);
      step();                               // edge k+2
      if (tbl[i].n > 0) begin
        chk($sformatf("lat_vld[%0d]", i), out_vld, 1'b1);
        chk($sformatf("first[%0d]", i), out_code, tbl[i].first);
        got = 0; lastc = 0;
        for (int c = 0; c < 20 && out_vld; c++) begin
          chk($sformatf("lastflag[%0d]", i), out_last, (got == tbl[i].n - 1));
          lastc = out_code;
          got++;
          step();
        end
        chk($sformatf("ncodes[%0d]", i), got, tbl[i].n);
        chk($sformatf("lastcode[%0d]", i), lastc, tbl[i].lastc);
      end else begin
        chk("zero_rdy", in_rdy, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
          if (out_vld) seen = 1'b1;
          step();
        end
        chk("zero_novld", seen, 1'b0);
      end
      chk($sformatf("ev[%0d]", i), ev_cnt, 16'(ev0 + 16'(tbl[i].n)));
    end

    // fill: stalled output, FIFO plus the work register absorb DEPTH+1 vectors
    do_reset();
    out_rdy = 1'b0; in_vld = 1'b1; strb = 11'h001; acc = 0;
    for (int c = 0; c < 7; c++) begin
      if (in_rdy) acc++;
      step();
    end
    chk("fill_acc", acc, DEPTH + 1);
    chk("fill_rdy", in_rdy, 1'b0);
    in_vld = 1'b0; strb = '0; out_rdy = 1'b1; got = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_vld) begin
        got++;
        chk("fill_code", out_code, 4'd0);
        chk("fill_last", out_last, 1'b1);
      end
      step();
    end
    chk("fill_ncodes", got, DEPTH + 1);
    chk("fill_rdy_back", in_rdy, 1'b1);
    chk("fill_ev", ev_cnt, 16'(DEPTH + 1));

    // mid-emit reset discards the pending codes
    do_reset();
    out_rdy = 1'b1; strb = 11'h7FF; in_vld = 1'b1;
    step();
    in_vld = 1'b0; strb = '0;
    wait_vld("mr_wait");
    step(); step(); step();
    chk("mr_ev3", ev_cnt, 16'd3);
    chk("mr_code", out_code, 4'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_vld0", out_vld, 1'b0);
    chk("mr_ev0", ev_cnt, 16'd0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (out_vld) seen = 1'b1;
      step();
    end
    chk("mr_quiet", seen, 1'b0);
    chk("mr_ev_after", ev_cnt, 16'd0);

`ifdef CU_ENC_PARITY_EN
    // parity travels with the code and holds through a stall
    do_reset();
    chk("par_rst", out_par, 1'b0);
    out_rdy = 1'b0; strb = 11'h080; in_vld = 1'b1;
    step();
    in_vld = 1'b0; strb = '0;
    wait_vld("par_wait");
    for (int c = 0; c < 3; c++) begin
      chk("par_code", out_code, 4'd7);
      chk("par_bit", out_par, 1'b1);
      step();
    end
    out_rdy = 1'b1;
    step();
    chk("par_done", out_vld, 1'b0);
    chk("par_ev", ev_cnt, 16'd1);
`endif

    // randomized run against the reference model
    do_reset();
    mfifo.delete(); mcur.delete(); mst = 0; mev = '0;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      int   v;
      int   pre_size;
      logic accd;
      if (cyc < 2400) begin
        in_vld  = ($urandom_range(0, 2) != 0);
        strb    = ($urandom_range(0, 7) == 0) ? 11'h000 : 11'($urandom_range(1, 2047));
        out_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        in_vld = 1'b0; strb = '0; out_rdy = 1'b1;
      end
      chk("rnd_rdy", in_rdy, (mfifo.size() < DEPTH));
      pre_size = mfifo.size();
      accd = in_vld && (pre_size < DEPTH);
      if (mst == 0) begin
        if (pre_size > 0) begin
          v = mfifo.pop_front();
          mcur.delete();
          for (int b = 0; b < 11; b++) if (v[b]) mcur.push_back(b);
          mst = 1;
        end
      end else if (mst == 1) begin
        mst = 2;
      end else if (out_rdy) begin
        void'(mcur.pop_front());
        mev++;
        if (mcur.size() == 0) mst = 0;
      end
      if (accd && strb != 0) mfifo.push_back(int'(strb));
      step();
      chk("rnd_vld", out_vld, (mst == 2));
      if (mst == 2) begin
        chk("rnd_code", out_code, mcur[0]);
        chk("rnd_last", out_last, (mcur.size() == 1));
      end
      chk("rnd_ev", ev_cnt, mev);
    end
    chk("rnd_end_vld", out_vld, 1'b0);
    chk("rnd_end_rdy", in_rdy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
